// File: rtl/ps2_kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard read-side controller.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef struct packed {
        logic       valid;
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_dec_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_BREAK) || (b == SC_EXT);
    endfunction

endpackage

// File: rtl/ps2_kbd_keytrack.sv
// Held-key tracker: repeat detection, key_down / held key and press counter.
module ps2_kbd_keytrack
    import ps2_kbd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clrn,
    input  key_dec_t         i_dec,
    output logic             o_repeat,
    output logic             o_key_down,
    output logic [7:0]       o_held_code,
    output logic             o_held_ext,
    output logic [CNT_W-1:0] o_press_cnt
);

    logic             r_repeat;
    logic             r_key_down;
    logic [7:0]       r_held_code;
    logic             r_held_ext;
    logic [CNT_W-1:0] r_press_cnt;
    logic             w_match;

    assign w_match = r_key_down && ({i_dec.ext, i_dec.code} == {r_held_ext, r_held_code});

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_repeat    <= 1'b0;
            r_key_down  <= 1'b0;
            r_held_code <= 8'h00;
            r_held_ext  <= 1'b0;
            r_press_cnt <= '0;
        end else if (i_dec.valid) begin
            if (i_dec.brk) begin
                // a release of some other key leaves the held key alone
                r_repeat <= 1'b0;
                if (w_match)
                    r_key_down <= 1'b0;
            end else if (w_match) begin
                r_repeat <= 1'b1;
            end else begin
                r_repeat    <= 1'b0;
                r_key_down  <= 1'b1;
                r_held_code <= i_dec.code;
                r_held_ext  <= i_dec.ext;
                r_press_cnt <= r_press_cnt + 1'b1;
            end
        end
    end

    assign o_repeat    = r_repeat;
    assign o_key_down  = r_key_down;
    assign o_held_code = r_held_code;
    assign o_held_ext  = r_held_ext;
    assign o_press_cnt = r_press_cnt;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Pops bytes from the ps2_keyboard FIFO, folds F0/E0 prefixes into key events
// and latches receiver overflow.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clrn,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             rx_overflow,
    output logic             rx_nextdata_n,
    output logic             evt_valid,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic             key_down,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    state_t     r_state;
    logic       r_nextdata_n;
    logic       r_evt_valid;
    logic [7:0] r_evt_code;
    logic       r_evt_ext;
    logic       r_evt_brk;
    logic       r_brk_f;
    logic       r_ext_f;
    logic       r_ovf;
    key_dec_t   w_dec;

    assign w_dec.valid = (r_state == IDLE) && rx_ready && !is_prefix(rx_data);
    assign w_dec.ext   = r_ext_f;
    assign w_dec.brk   = r_brk_f;
    assign w_dec.code  = rx_data;

    // GAP gives the receiver one cycle to update ready after the pop strobe
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_state      <= IDLE;
            r_nextdata_n <= 1'b1;
            r_evt_valid  <= 1'b0;
            r_evt_code   <= 8'h00;
            r_evt_ext    <= 1'b0;
            r_evt_brk    <= 1'b0;
            r_brk_f      <= 1'b0;
            r_ext_f      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_evt_valid <= 1'b0;
                    if (rx_ready) begin
                        r_state      <= POP;
                        r_nextdata_n <= 1'b0;
                        if (rx_data == SC_BREAK) begin
                            r_brk_f <= 1'b1;
                        end else if (rx_data == SC_EXT) begin
                            r_ext_f <= 1'b1;
                        end else begin
                            r_evt_valid <= 1'b1;
                            r_evt_code  <= rx_data;
                            r_evt_ext   <= r_ext_f;
                            r_evt_brk   <= r_brk_f;
                            r_brk_f     <= 1'b0;
                            r_ext_f     <= 1'b0;
                        end
                    end
                end
                POP: begin
                    r_state      <= GAP;
                    r_nextdata_n <= 1'b1;
                    r_evt_valid  <= 1'b0;
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state      <= IDLE;
                    r_nextdata_n <= 1'b1;
                    r_evt_valid  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn)
            r_ovf <= 1'b0;
        else if (rx_overflow)
            r_ovf <= 1'b1;
        else if (ovf_clr)
            r_ovf <= 1'b0;
    end

    ps2_kbd_keytrack #(.CNT_W(CNT_W)) u_keytrack (
        .clock       (clock),
        .clrn        (clrn),
        .i_dec       (w_dec),
        .o_repeat    (evt_repeat),
        .o_key_down  (key_down),
        .o_held_code (held_code),
        .o_held_ext  (held_ext),
        .o_press_cnt (press_cnt)
    );

    assign rx_nextdata_n = r_nextdata_n;
    assign evt_valid     = r_evt_valid;
    assign evt_code      = r_evt_code;
    assign evt_ext       = r_evt_ext;
    assign evt_break     = r_evt_brk;
    assign ovf_sticky    = r_ovf;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: FIFO model plus a key-event reference model.
module tb_ps2_kbd_ctrl;

    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             clrn = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_ready = 1'b0;
    logic             rx_overflow = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             rx_nextdata_n;
    logic             evt_valid;
    logic [7:0]       evt_code;
    logic             evt_ext;
    logic             evt_break;
    logic             evt_repeat;
    logic             key_down;
    logic [7:0]       held_code;
    logic             held_ext;
    logic [CNT_W-1:0] press_cnt;
    logic             ovf_sticky;

    ps2_kbd_ctrl #(.CNT_W(CNT_W)) dut (
        .clock(clock), .clrn(clrn), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .rx_nextdata_n(rx_nextdata_n),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext),
        .evt_break(evt_break), .evt_repeat(evt_repeat), .key_down(key_down),
        .held_code(held_code), .held_ext(held_ext), .press_cnt(press_cnt),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] code;
    } ev_t;

    logic [7:0] fifo[$];
    ev_t        exp_q[$];

    logic       m_brk, m_ext, m_down, m_hext;
    logic [7:0] m_hcode;
    int         m_cnt;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pops = 0;
    int   last_pop = -1;
    int   last_gap = 0;
    logic prev_nd = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_down = 0; m_hext = 0; m_hcode = 8'h00; m_cnt = 0;
        fifo.delete();
        exp_q.delete();
    endtask

    // spec rules in plain form: prefixes arm flags, other bytes become events
    task automatic send(input logic [7:0] b);
        ev_t  e;
        logic same;
        fifo.push_back(b);
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            same   = m_down && (m_ext == m_hext) && (b == m_hcode);
            e.ext  = m_ext;
            e.brk  = m_brk;
            e.rep  = !m_brk && same;
            e.code = b;
            exp_q.push_back(e);
            if (!m_brk && !same) begin
                m_down = 1; m_hext = m_ext; m_hcode = b;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end else if (m_brk && same) begin
                m_down = 0;
            end
            m_brk = 0; m_ext = 0;
        end
    endtask

    task automatic tick();
        ev_t e;
        @(negedge clock);
        cyc++;
        if (rx_nextdata_n === 1'b0) begin
            pops++;
            chk("nd_one_cycle", 32'(prev_nd), 32'd1);
            chk("pop_nonempty", 32'(fifo.size() != 0), 32'd1);
            if (last_pop >= 0) begin
                last_gap = cyc - last_pop;
                chk("pop_spacing", 32'(last_gap >= 3), 32'd1);
            end
            last_pop = cyc;
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        prev_nd = rx_nextdata_n;
        if (evt_valid === 1'b1) begin
            chk("evt_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("evt_fields", 32'({evt_ext, evt_break, evt_repeat, evt_code}), 32'(e));
            end
        end
        rx_ready = (fifo.size() != 0);
        rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_key_down"}, 32'(key_down), 32'(m_down));
        chk({tag, "_held_code"}, 32'(held_code), 32'(m_hcode));
        chk({tag, "_held_ext"}, 32'(held_ext), 32'(m_hext));
        chk({tag, "_press_cnt"}, 32'(press_cnt), 32'(m_cnt));
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(n < budget), 32'd1);
        repeat (3) tick();
        chk({tag, "_events_left"}, 32'(exp_q.size()), 32'd0);
        check_state(tag);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        model_reset();
        rx_ready = 1'b0;
        tick();
        chk("rst_nd", 32'(rx_nextdata_n), 32'd1);
        chk("rst_evt", 32'({evt_valid, evt_code, evt_ext, evt_break, evt_repeat}), 32'd0);
        chk("rst_key", 32'({key_down, held_code, held_ext, press_cnt}), 32'd0);
        clrn = 1'b1;
        tick();
    endtask

    initial begin
        int p0;
        int n;
        logic [7:0] b;
        model_reset();
        tick();
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        do_reset();

        // 1: make then break of 1C
        send(8'h1C);
        drain("t1a", 100);
        chk("t1_down", 32'(key_down), 32'd1);
        send(8'hF0); send(8'h1C);
        drain("t1b", 100);
        chk("t1_cnt", 32'(press_cnt), 32'd1);
        chk("t1_code", 32'(held_code), 32'h1C);

        // 2: typematic repeats of 1B
        repeat (3) send(8'h1B);
        send(8'hF0); send(8'h1B);
        drain("t2", 200);
        chk("t2_cnt", 32'(press_cnt), 32'd2);
        chk("t2_up", 32'(key_down), 32'd0);

        // 3: extended key press and release
        send(8'hE0); send(8'h75);
        drain("t3a", 100);
        chk("t3_hext", 32'(held_ext), 32'd1);
        send(8'hE0); send(8'hF0); send(8'h75);
        drain("t3b", 100);

        // 4: two bytes queued back to back
        p0 = pops;
        send(8'h1C); send(8'h32);
        drain("t4", 100);
        chk("t4_pops", 32'(pops - p0), 32'd2);
        chk("t4_gap", 32'(last_gap), 32'd3);
        chk("t4_code", 32'(held_code), 32'h32);

        // 5: 256 press/release pairs wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            b = 8'((i >> 1) + 1);
            if (i[0]) send(8'hE0);
            send(b);
            if (i[0]) send(8'hE0);
            send(8'hF0);
            send(b);
        end
        drain("t5", 6000);
        chk("t5_wrap", 32'(press_cnt), 32'd0);

        // randomized byte mix
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0: send(8'hF0);
                1: send(8'hE0);
                2: send(8'h1C);
                3: send(8'h1B);
                4: send(8'h32);
                default: send(8'($urandom_range(1, 8'hDF)));
            endcase
        end
        drain("rnd", 2000);

        // overflow sticky: set wins over clear
        rx_overflow = 1'b1; ovf_clr = 1'b1;
        tick();
        chk("ovf_set_wins", 32'(ovf_sticky), 32'd1);
        rx_overflow = 1'b0;
        tick();
        chk("ovf_clr", 32'(ovf_sticky), 32'd0);
        ovf_clr = 1'b0;
        rx_overflow = 1'b1;
        tick();
        rx_overflow = 1'b0;
        tick();
        chk("ovf_hold", 32'(ovf_sticky), 32'd1);

        // 6: reset during the POP of an F0
        send(8'hF0);
        n = 0;
        while (rx_nextdata_n !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_pop_seen", 32'(rx_nextdata_n === 1'b0), 32'd1);
        clrn = 1'b0;
        #1;
        chk("t6_nd_async", 32'(rx_nextdata_n), 32'd1);
        model_reset();
        rx_ready = 1'b0;
        tick();
        chk("t6_ovf_rst", 32'(ovf_sticky), 32'd0);
        clrn = 1'b1;
        tick();
        send(8'h1C);
        drain("t6", 100);
        chk("t6_make", 32'(key_down), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
